panel_input: RTL and testbench
==============================

# panel_input

Front-panel input unit for the teaching CPU board: the input-side counterpart of the seven-segment/LED display path. It synchronizes and debounces three push-buttons, latches the 8-bit slide switches as a manual memory address or data byte, and issues single-word writes to memory over a req/ack handshake. It also produces a clean single-step pulse for the CPU controller. It sits between the board pins in top.v and the memory's manual-load port.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required before a key's debounced level changes (≥2; board build overrides to ~20000)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_addr_n  in  1  raw push-button, active-low: load SW as address
- key_data_n  in  1  raw push-button, active-low: load SW as data and write
- key_step_n  in  1  raw push-button, active-low: single-step request
- SW  in  8  slide switches (quasi-static, sampled on key events)
- mem_wr_ack  in  1  memory accepts the current write
- mem_wr_req  out  1  write request, held until acked
- mem_wr_addr  out  8  write address (current manual address register)
- mem_wr_data  out  8  write data register
- step_pulse  out  1  one-cycle single-step strobe
- busy  out  1  high while a write is outstanding

## Operation
- Per key: 2-flop synchronizer → debounce counter → falling-edge (press) detector. Debounced state resets to released (1).
- Counter: clears whenever the synchronized sample equals the debounced state; increments otherwise; on reaching DEBOUNCE_CYCLES the debounced state flips and the counter clears. Any bounce back before that restarts the count.
- Press event: one-cycle registered pulse in the cycle after the debounced level goes 1→0. Release produces no event.
- FSM states IDLE, WRITE.
  - IDLE, addr event: addr_reg ← SW.
  - IDLE, data event (no addr event same cycle): data_reg ← SW, go WRITE.
  - IDLE, addr and data events in the same cycle: address load wins, data event dropped.
  - WRITE: mem_wr_req = 1, addr/data held stable; on mem_wr_ack = 1 → addr_reg ← addr_reg + 1 (8-bit wrap, 0xFF → 0x00), go IDLE.
  - WRITE: addr and data events are ignored (dropped, not queued).
- Step event → step_pulse for one cycle, in any FSM state, independent of writes.
- mem_wr_ack while IDLE is ignored.
- busy = (state == WRITE).
- Reset (any time, including mid-write): state IDLE, addr_reg = 0x00, data_reg = 0x00, all outputs 0, synchronizers and debounced states = 1, counters = 0. A write in progress is abandoned; no increment.

## Timing
- Raw press held clean from cycle 0: synchronized at cycle 2, debounced at cycle 2+DEBOUNCE_CYCLES, event/step_pulse at cycle 3+DEBOUNCE_CYCLES.
- Data event at cycle t: mem_wr_req and busy rise at t+1, with mem_wr_data = SW sampled at t.
- Ack sampled high at cycle u: req/busy low and addr incremented at u+1. A new write can start with an event at u+1 at the earliest.
- Ack may already be high when req rises; the write then completes after one req cycle.
- Outputs are all registered; no combinational path from inputs to outputs.

## Structure
- Shared package `panel_pkg`: FSM state enum (IDLE, WRITE), `PANEL_W = 8` data/address width, debounced-released constant.
- One sub-module `key_debounce` (synchronizer + counter + press pulse, parameter DEBOUNCE_CYCLES), instantiated three times. The FSM, registers and handshake live in panel_input.

## Test plan
- Use DEBOUNCE_CYCLES=4. Clean key_data_n press with SW=0x3C, addr 0x00, ack tied 1 → req high exactly at cycle 8 for one cycle, addr/data = 0x00/0x3C, addr becomes 0x01.
- key_data_n bounces 1→0→1→0 with glitches of 3 cycles, then held low → a single write only, 4 stable cycles after the last transition.
- SW=0xFF, key_addr press, then data press with ack delayed 5 cycles → req held 5 cycles with 0xFF stable; addr wraps to 0x00. A second data press during WRITE produces no write.
- key_addr_n and key_data_n pressed in the same cycle (SW=0x10) → addr_reg = 0x10, no req.
- key_step_n pressed during an outstanding write → step_pulse exactly one cycle; write unaffected.
- rst asserted mid-WRITE (ack never given) → req/busy drop immediately, addr = 0x00. After release, the held key produces no spurious event until released and pressed again.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared types and constants for the front-panel input unit.
package panel_pkg;

    localparam int   PANEL_W      = 8;
    localparam logic KEY_RELEASED = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } panel_state_e;

    typedef struct packed {
        logic [PANEL_W-1:0] addr;
        logic [PANEL_W-1:0] data;
    } wr_cmd_t;

endpackage

// File: rtl/key_debounce.sv
// Purpose: synchronize, debounce and press-detect one active-low push-button.
// Latency: press_o pulses DEBOUNCE_CYCLES+3 cycles after a clean raw press.
// Backpressure: none; events are one-cycle strobes and are never held.
module key_debounce
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [1:0]       fill_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic             armed_q, armed_d;
    logic             press_q, press_d;

    // A key held through reset must be seen released once (a real sample,
    // not the reset fill of the synchronizer) before it may generate a press.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = ~deb_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        armed_d = armed_q | (fill_q[1] & (sync2_q == KEY_RELEASED));
        press_d = armed_q & (deb_prev_q == KEY_RELEASED) & (deb_q != KEY_RELEASED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= KEY_RELEASED;
            sync2_q    <= KEY_RELEASED;
            fill_q     <= '0;
            cnt_q      <= '0;
            deb_q      <= KEY_RELEASED;
            deb_prev_q <= KEY_RELEASED;
            armed_q    <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= key_n_i;
            sync2_q    <= sync1_q;
            fill_q     <= {fill_q[0], 1'b1};
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            armed_q    <= armed_d;
            press_q    <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/panel_input.sv
// Purpose: front-panel keys to manual memory address/data load and single-step strobe.
// Latency: write request one cycle after a data press event; step strobe equals its press event.
// Backpressure: write held until mem_wr_ack; key events arriving while busy are dropped.
module panel_input
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_addr_n,
    input  logic               key_data_n,
    input  logic               key_step_n,
    input  logic [PANEL_W-1:0] SW,
    input  logic               mem_wr_ack,
    output logic               mem_wr_req,
    output logic [PANEL_W-1:0] mem_wr_addr,
    output logic [PANEL_W-1:0] mem_wr_data,
    output logic               step_pulse,
    output logic               busy
);

    logic addr_ev, data_ev, step_ev;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_addr (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_addr_n),
        .press_o (addr_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_data (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_data_n),
        .press_o (data_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_step_n),
        .press_o (step_ev)
    );

    panel_state_e state_q, state_d;
    wr_cmd_t      cmd_q, cmd_d;

    // Address load has priority over a same-cycle data press.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            ST_IDLE: begin
                if (addr_ev) begin
                    cmd_d.addr = SW;
                end else if (data_ev) begin
                    cmd_d.data = SW;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_wr_ack) begin
                    cmd_d.addr = cmd_q.addr + PANEL_W'(1);
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    assign mem_wr_req  = (state_q == ST_WRITE);
    assign busy        = (state_q == ST_WRITE);
    assign mem_wr_addr = cmd_q.addr;
    assign mem_wr_data = cmd_q.data;
    assign step_pulse  = step_ev;

endmodule

// File: tb/tb_panel_input.sv
// Bench for panel_input: directed key scenarios plus random key/ack traffic against a history-based model.
module tb_panel_input;

    localparam int N    = 4;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_addr_n = 1'b1, key_data_n = 1'b1, key_step_n = 1'b1;
    logic [7:0] SW = 8'h00;
    logic       mem_wr_ack = 1'b0;
    logic       mem_wr_req, step_pulse, busy;
    logic [7:0] mem_wr_addr, mem_wr_data;

    panel_input #(.DEBOUNCE_CYCLES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_addr_n  (key_addr_n),
        .key_data_n  (key_data_n),
        .key_step_n  (key_step_n),
        .SW          (SW),
        .mem_wr_ack  (mem_wr_ack),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .step_pulse  (step_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference model: raw key history since reset; debounced level after edge e
    // flips when the last N synchronized samples (raw of cycle e-3 back) all differ.
    bit         raw_h [3][MAXC];
    bit         deb_h [3][MAXC+2];
    bit         ev_m [3];
    bit         armed_m [3];
    int         cyc;
    bit         m_busy;
    logic [7:0] m_addr, m_data;
    int         busy_cnt;
    int         m_writes = 0, d_writes = 0;
    int         ack_delay = 0;
    bit         ack_rand = 0;

    // per-scenario observation of the DUT
    int         p_start, w0, req_first, req_len, step_cnt, unstable;
    logic [7:0] req_addr, req_data;

    function automatic bit raw_at(input int k, input int i);
        return (i < 0) ? 1'b1 : raw_h[k][i];
    endfunction

    function automatic bit deb_at(input int k, input int e);
        return (e < 0) ? 1'b1 : deb_h[k][e];
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            ev_m[k]     = 1'b0;
            armed_m[k]  = 1'b0;
            deb_h[k][0] = 1'b1;
        end
        m_busy   = 1'b0;
        m_addr   = 8'h00;
        m_data   = 8'h00;
        busy_cnt = 0;
    endtask

    task automatic model_edge(input logic [7:0] sw, input bit ack);
        int e;
        bit cur, flip;
        bit ev_new [3];
        e = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            cur  = deb_h[k][cyc];
            flip = 1'b1;
            for (int i = e - 3 - N + 1; i <= e - 3; i++)
                if (raw_at(k, i) == cur) flip = 1'b0;
            deb_h[k][e] = flip ? ~cur : cur;
            ev_new[k]   = armed_m[k] && deb_at(k, e - 2) && !deb_at(k, e - 1);
            armed_m[k]  = armed_m[k] || (e - 3 >= 0 && raw_at(k, e - 3));
        end
        if (!m_busy) begin
            if (ev_m[0]) m_addr = sw;
            else if (ev_m[1]) begin
                m_data = sw;
                m_busy = 1'b1;
            end
        end else if (ack) begin
            m_addr = m_addr + 8'h01;
            m_busy = 1'b0;
            m_writes++;
        end
        for (int k = 0; k < 3; k++) ev_m[k] = ev_new[k];
        busy_cnt = m_busy ? busy_cnt + 1 : 0;
        cyc = e;
    endtask

    task automatic mark();
        p_start   = cyc;
        w0        = d_writes;
        req_first = -1;
        req_len   = 0;
        step_cnt  = 0;
        unstable  = 0;
    endtask

    task automatic cyc_run(input bit ka, input bit kd, input bit ks, input logic [7:0] sw, input int n);
        bit ack;
        repeat (n) begin
            if (cyc >= MAXC - 4) begin
                $display("FAIL cycle_budget: got=%0d want<%0d", cyc, MAXC - 4);
                $fatal(1, "cycle budget exceeded");
            end
            ack = ack_rand ? bit'($urandom_range(0, 1)) : (busy_cnt >= ack_delay);
            key_addr_n = ka;
            key_data_n = kd;
            key_step_n = ks;
            SW         = sw;
            mem_wr_ack = ack;
            raw_h[0][cyc] = ka;
            raw_h[1][cyc] = kd;
            raw_h[2][cyc] = ks;
            if (mem_wr_req && ack) d_writes++;
            model_edge(sw, ack);
            @(negedge clk);
            chk("req",  mem_wr_req,  m_busy);
            chk("busy", busy,        m_busy);
            chk("addr", mem_wr_addr, m_addr);
            chk("data", mem_wr_data, m_data);
            chk("step", step_pulse,  ev_m[2]);
            if (mem_wr_req) begin
                if (req_first < 0) begin
                    req_first = cyc - p_start;
                    req_addr  = mem_wr_addr;
                    req_data  = mem_wr_data;
                end
                req_len++;
                if (mem_wr_addr !== req_addr || mem_wr_data !== req_data) unstable++;
            end
            if (step_pulse) step_cnt++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req",  mem_wr_req,  1'b0);
        chk("rst_busy", busy,        1'b0);
        chk("rst_addr", mem_wr_addr, 8'h00);
        chk("rst_data", mem_wr_data, 8'h00);
        chk("rst_step", step_pulse,  1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2;
        do_reset();
        cyc_run(1, 1, 1, 8'h3C, 10);

        // clean data press, ack tied high
        ack_delay = 0;
        mark();
        cyc_run(1, 0, 1, 8'h3C, 14);
        chk("t1_req_cycle", req_first, 8);
        chk("t1_req_len",   req_len, 1);
        chk("t1_req_addr",  req_addr, 8'h00);
        chk("t1_req_data",  req_data, 8'h3C);
        chk("t1_writes",    d_writes - w0, 1);
        cyc_run(1, 1, 1, 8'h3C, 10);
        chk("t1_addr_inc",  mem_wr_addr, 8'h01);

        // bouncing data key: 3-cycle glitches, then held
        mark();
        cyc_run(1, 0, 1, 8'h5A, 3);
        cyc_run(1, 1, 1, 8'h5A, 3);
        cyc_run(1, 0, 1, 8'h5A, 16);
        cyc_run(1, 1, 1, 8'h5A, 10);
        chk("t2_req_cycle", req_first, 14);
        chk("t2_writes",    d_writes - w0, 1);
        chk("t2_req_data",  req_data, 8'h5A);

        // address 0xFF, write with ack delayed 5 cycles, address wraps
        cyc_run(0, 1, 1, 8'hFF, 10);
        cyc_run(1, 1, 1, 8'hFF, 10);
        chk("t3_addr_load", mem_wr_addr, 8'hFF);
        ack_delay = 5;
        mark();
        cyc_run(1, 0, 1, 8'hFF, 10);
        cyc_run(1, 1, 1, 8'hFF, 10);
        chk("t3_req_len",   req_len, 5);
        chk("t3_req_addr",  req_addr, 8'hFF);
        chk("t3_req_data",  req_data, 8'hFF);
        chk("t3_stable",    unstable, 0);
        chk("t3_addr_wrap", mem_wr_addr, 8'h00);

        // second data press while the write is outstanding is dropped
        ack_delay = 40;
        mark();
        cyc_run(1, 0, 1, 8'h11, 10);
        cyc_run(1, 1, 1, 8'h22, 8);
        cyc_run(1, 0, 1, 8'h22, 10);
        cyc_run(1, 1, 1, 8'h22, 32);
        chk("t3b_writes",   d_writes - w0, 1);
        chk("t3b_req_len",  req_len, 40);
        chk("t3b_req_data", req_data, 8'h11);
        chk("t3b_stable",   unstable, 0);

        // simultaneous address and data presses
        ack_delay = 0;
        mark();
        cyc_run(0, 0, 1, 8'h10, 10);
        cyc_run(1, 1, 1, 8'h10, 10);
        chk("t4_no_req",    req_len, 0);
        chk("t4_addr",      mem_wr_addr, 8'h10);

        // step press during an outstanding write
        ack_delay = 20;
        mark();
        cyc_run(1, 0, 1, 8'h33, 10);
        cyc_run(1, 1, 0, 8'h33, 8);
        cyc_run(1, 1, 1, 8'h33, 12);
        chk("t5_step_cnt",  step_cnt, 1);
        chk("t5_writes",    d_writes - w0, 1);
        chk("t5_req_len",   req_len, 20);
        chk("t5_req_data",  req_data, 8'h33);

        // reset mid-write with the data key held through it
        ack_delay = 1000;
        cyc_run(1, 0, 1, 8'h44, 12);
        chk("t6_pre_busy",  busy, 1'b1);
        do_reset();
        ack_delay = 0;
        mark();
        cyc_run(1, 0, 1, 8'h44, 20);
        chk("t6_no_req",    req_len, 0);
        cyc_run(1, 1, 1, 8'h44, 10);
        cyc_run(1, 0, 1, 8'h44, 12);
        cyc_run(1, 1, 1, 8'h44, 10);
        chk("t6_writes",    d_writes - w0, 1);
        chk("t6_req_addr",  req_addr, 8'h00);
        chk("t6_addr",      mem_wr_addr, 8'h01);

        // random key levels, switches and ack
        ack_rand = 1;
        for (int s = 0; s < 250; s++) begin
            cyc_run(bit'($urandom_range(0, 9) >= 4), bit'($urandom_range(0, 9) >= 4),
                    bit'($urandom_range(0, 9) >= 4), 8'($urandom), $urandom_range(1, 12));
        end
        chk("rand_writes", d_writes, m_writes);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
